memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/riscv_pkg.sv | 18 +
 rtl/memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the instruction/data memory arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } arb_owner_t;

    // Wide enough for the largest supported abort limit (65535).
    localparam int CountBits = 16;

endpackage

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory port with a single outstanding
// transaction, alternating priority under contention and an abort timer.
module memory_arbiter
    import riscv_pkg::*;
#(
    parameter int RegBits       = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 if_req_i,
    input  logic [RegBits-1:0]   if_addr_i,
    output logic                 if_gnt_o,
    output logic                 if_rvalid_o,
    output logic [RegBits-1:0]   if_rdata_o,

    input  logic                 dm_req_i,
    input  logic                 dm_we_i,
    input  logic [RegBits-1:0]   dm_addr_i,
    input  logic [RegBits-1:0]   dm_wdata_i,
    input  logic [RegBits/8-1:0] dm_be_i,
    output logic                 dm_gnt_o,
    output logic                 dm_rvalid_o,
    output logic [RegBits-1:0]   dm_rdata_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [RegBits-1:0]   mem_addr_o,
    output logic [RegBits-1:0]   mem_wdata_o,
    output logic [RegBits/8-1:0] mem_be_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [RegBits-1:0]   mem_rdata_i,

    output logic                 timeout_o
);

    localparam int BeBits = RegBits / 8;
    localparam logic [CountBits-1:0] TimeoutLimit = CountBits'(TimeoutCycles);
    localparam logic [CountBits-1:0] CountMax     = '1;

    arb_state_t          state, state_next;
    arb_owner_t          owner, prio, winner;
    logic [RegBits-1:0]  lat_addr, lat_wdata;
    logic                lat_we;
    logic [BeBits-1:0]   lat_be;
    logic [CountBits-1:0] count;
    logic                any_req, done, timeout_hit;

    // Arbitration and transaction-end conditions.
    always_comb begin
        any_req = if_req_i | dm_req_i;
        if (if_req_i && dm_req_i) begin
            winner = prio;
        end else if (dm_req_i) begin
            winner = OWNER_DM;
        end else begin
            winner = OWNER_IF;
        end
        done        = (state == RESP) && mem_rvalid_i;
        // Completion beats an abort that lands in the same cycle.
        timeout_hit = (state != IDLE) && (count == TimeoutLimit) && !done;
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (any_req) state_next = REQ;
            REQ: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (mem_gnt_i) begin
                    state_next = RESP;
                end
            end
            RESP: if (done || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_gnt_o    = 1'b0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        timeout_o   = 1'b0;
        // Reset overrides whatever the state register still holds.
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        if_gnt_o = (winner == OWNER_IF);
                        dm_gnt_o = (winner == OWNER_DM);
                    end
                end
                REQ: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = lat_we;
                    mem_addr_o  = lat_addr;
                    mem_wdata_o = lat_wdata;
                    mem_be_o    = lat_be;
                end
                default: ;
            endcase
            timeout_o = timeout_hit;
            if (done || timeout_hit) begin
                if (owner == OWNER_IF) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = done ? mem_rdata_i : '0;
                end else begin
                    dm_rvalid_o = 1'b1;
                    dm_rdata_o  = done ? mem_rdata_i : '0;
                end
            end
        end
    end

    // Latched request fields, priority register and saturating timer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner     <= OWNER_IF;
            prio      <= OWNER_DM;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            count     <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                owner <= winner;
                prio  <= (winner == OWNER_IF) ? OWNER_DM : OWNER_IF;
                count <= '0;
                if (winner == OWNER_IF) begin
                    lat_addr  <= if_addr_i;
                    lat_wdata <= '0;
                    lat_we    <= 1'b0;
                    lat_be    <= '1;
                end else begin
                    lat_addr  <= dm_addr_i;
                    lat_wdata <= dm_wdata_i;
                    lat_we    <= dm_we_i;
                    lat_be    <= dm_be_i;
                end
            end
        end else if (count != CountMax) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, fetch, contention, write, slow
// memory, timeout and reset during a response.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_req, mem_we, timeout;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [5:0]  ctl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ctl = {if_gnt, dm_gnt, mem_req, if_rvalid, dm_rvalid, timeout};

    memory_arbiter #(
        .RegBits       (32),
        .TimeoutCycles (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt),
        .if_rvalid_o  (if_rvalid),
        .if_rdata_o   (if_rdata),
        .dm_req_i     (dm_req),
        .dm_we_i      (dm_we),
        .dm_addr_i    (dm_addr),
        .dm_wdata_i   (dm_wdata),
        .dm_be_i      (dm_be),
        .dm_gnt_o     (dm_gnt),
        .dm_rvalid_o  (dm_rvalid),
        .dm_rdata_o   (dm_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .timeout_o    (timeout)
    );

    // Inputs change just after the rising edge; outputs are read on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        next_cycle();
        clear_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [100:0] data_bus;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            rst = 1; if_req = 1; dm_req = 1; dm_we = 1; mem_gnt = 1; mem_rvalid = 1;
            if_addr = 32'h11; dm_addr = 32'h22; dm_wdata = 32'h33; dm_be = 4'hF;
            mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            data_bus = {if_rdata, dm_rdata, mem_addr, mem_be, mem_we};
            checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl: ctl=%b expected 000000", ctl); end
            checks++; if (data_bus !== '0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: bus=%h wdata=%h expected 0", data_bus, mem_wdata); end
        end
        next_cycle();
        clear_inputs(); rst = 0;
        @(negedge clk);
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL idle_ctl: ctl=%b expected 000000", ctl); end
        // Memory strobes in IDLE must not disturb anything.
        next_cycle();
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL idle_ignore_ctl: ctl=%b expected 000000", ctl); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL idle_ignore_rdata: if=%h dm=%h expected 0", if_rdata, dm_rdata); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_fetch();
        next_cycle();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL fetch_gnt: ctl=%b expected 100000", ctl); end
        next_cycle();
        if_req = 0; if_addr = 32'h0; mem_gnt = 1;
        @(negedge clk);
        checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL fetch_req: ctl=%b expected 001000", ctl); end
        checks++; if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h100, 4'hF}) begin errors++; $display("FAIL fetch_fields: we=%b addr=%h be=%h expected 0 100 f", mem_we, mem_addr, mem_be); end
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        checks++; if (ctl !== 6'b000100) begin errors++; $display("FAIL fetch_rvalid: ctl=%b expected 000100", ctl); end
        checks++; if (if_rdata !== 32'h0050_0093 || dm_rdata !== 32'h0) begin errors++; $display("FAIL fetch_rdata: if=%h dm=%h expected 00500093 0", if_rdata, dm_rdata); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL fetch_done: ctl=%b expected 000000", ctl); end
    endtask

    task automatic test_contention();
        logic        exp_dm;
        logic [5:0]  exp_ctl;
        logic [31:0] exp_addr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_dm   = (i % 2 == 0);
            exp_addr = exp_dm ? 32'h300 : 32'h100;
            next_cycle();
            if_req = 1; dm_req = 1; if_addr = 32'h100; dm_addr = 32'h300;
            dm_we = 0; dm_be = 4'h3; dm_wdata = 32'h55; mem_gnt = 0; mem_rvalid = 0;
            @(negedge clk);
            exp_ctl = exp_dm ? 6'b010000 : 6'b100000;
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL contend_gnt[%0d]: ctl=%b expected %b", i, ctl, exp_ctl); end
            next_cycle();
            mem_gnt = 1;
            @(negedge clk);
            checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL contend_req[%0d]: ctl=%b expected 001000", i, ctl); end
            checks++; if (mem_addr !== exp_addr || mem_be !== (exp_dm ? 4'h3 : 4'hF)) begin errors++; $display("FAIL contend_fields[%0d]: addr=%h be=%h expected %h", i, mem_addr, mem_be, exp_addr); end
            next_cycle();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + i;
            @(negedge clk);
            exp_ctl = exp_dm ? 6'b000010 : 6'b000100;
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL contend_rvalid[%0d]: ctl=%b expected %b", i, ctl, exp_ctl); end
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_write();
        next_cycle();
        dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        @(negedge clk);
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL write_gnt: ctl=%b expected 010000", ctl); end
        next_cycle();
        dm_req = 0; dm_we = 0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0; mem_gnt = 1;
        @(negedge clk);
        checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL write_req: ctl=%b expected 001000", ctl); end
        checks++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF}) begin errors++; $display("FAIL write_fields: we=%b addr=%h wdata=%h be=%h expected 1 2000 deadbeef f", mem_we, mem_addr, mem_wdata, mem_be); end
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (ctl !== 6'b000010) begin errors++; $display("FAIL write_ack: ctl=%b expected 000010", ctl); end
        checks++; if (dm_rdata !== 32'h1234_5678 || if_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata: dm=%h if=%h expected 12345678 0", dm_rdata, if_rdata); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_slow_memory();
        next_cycle();
        if_req = 1; if_addr = 32'h400;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL slow_gnt: ctl=%b expected 100000", ctl); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if_req = 0; if_addr = 32'hBAD0 + k; mem_gnt = (k == 3); mem_rvalid = (k == 1);
            @(negedge clk);
            checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL slow_req[%0d]: ctl=%b expected 001000", k, ctl); end
            checks++; if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h400, 4'hF}) begin errors++; $display("FAIL slow_fields[%0d]: we=%b addr=%h be=%h expected 0 400 f", k, mem_we, mem_addr, mem_be); end
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            mem_gnt = 0; mem_rvalid = 0;
            @(negedge clk);
            checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL slow_wait[%0d]: ctl=%b expected 000000", k, ctl); end
        end
        // Response lands on the same cycle the timer hits its limit.
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        checks++; if (ctl !== 6'b000100) begin errors++; $display("FAIL slow_rvalid: ctl=%b expected 000100", ctl); end
        checks++; if (if_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL slow_rdata: if=%h expected cafe0001", if_rdata); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL slow_done: ctl=%b expected 000000", ctl); end
    endtask

    task automatic test_timeout();
        next_cycle();
        dm_req = 1; dm_addr = 32'h500;
        @(negedge clk);
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL to_gnt: ctl=%b expected 010000", ctl); end
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            dm_req = 0;
            @(negedge clk);
            checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL to_wait[%0d]: ctl=%b expected 001000", k, ctl); end
        end
        next_cycle();
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (ctl !== 6'b001011) begin errors++; $display("FAIL to_pulse: ctl=%b expected 001011", ctl); end
        checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: dm=%h expected 0", dm_rdata); end
        next_cycle();
        clear_inputs();
        if_req = 1; if_addr = 32'h600;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL to_idle: ctl=%b expected 100000", ctl); end
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        next_cycle();
        if_req = 1; if_addr = 32'h700;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rr_gnt: ctl=%b expected 100000", ctl); end
        next_cycle();
        if_req = 0; mem_gnt = 1;
        @(negedge clk);
        checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL rr_req: ctl=%b expected 001000", ctl); end
        next_cycle();
        mem_gnt = 0; rst = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        checks++; if (ctl !== 6'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rr_during: ctl=%b rdata=%h expected 000000 0", ctl, if_rdata); end
        next_cycle();
        rst = 0; if_req = 1; dm_req = 1; dm_addr = 32'h800;
        @(negedge clk);
        checks++; if (ctl !== 6'b010000) begin errors++; $display("FAIL rr_after: ctl=%b expected 010000", ctl); end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_fetch();
        test_contention();
        test_write();
        test_slow_memory();
        test_timeout();
        test_reset_in_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
